mxv_frame_ctrl: RTL
===================

MXV_FRAME_CTRL -- requirements
Module: mxv_frame_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 rx_valid  input  1  one-cycle strobe, received UART byte present on rx_data.
REQ-004 rx_data  input  8  received byte.
REQ-005 compute_done  input  1  one-cycle strobe from MxV datapath, computation finished.
REQ-006 n  output  4  configured dimension (1..8); 0 means unconfigured.
REQ-007 row_wr  output  8  one-hot matrix-row FIFO write enable.
REQ-008 vec_wr  output  1  vector FIFO write enable.
REQ-009 wr_data  output  8  data for row_wr/vec_wr.
REQ-010 clear  output  1  one-cycle pulse, flush all FIFOs.
REQ-011 start  output  1  one-cycle pulse, launch computation.
REQ-012 frame_err  output  1  one-cycle pulse, malformed or illegal frame.
REQ-013 busy  output  1  high from start pulse until compute_done.

Function
REQ-014 Frame format: 0xFE, L, CMD, L-1 payload bytes, 0xEF; L counts CMD plus payload.
REQ-015 Commands: 0x01 SIZE (L=2, payload N), 0x02 START (L=1), 0x03 MATRIX (L=1+N*N), 0x04 VECTOR (L=1+N), 0x05 CLEAN (L=1).
REQ-016 States: IDLE, LEN, CMD, PAYLOAD, END, EXEC, WAIT_DONE; state advances only on rx_valid except EXEC (one cycle, unconditional) and WAIT_DONE (exits on compute_done).
REQ-017 IDLE: 0xFE -> LEN; any other byte dropped, no frame_err.
REQ-018 LEN -> CMD; CMD checks code and L against REQ-015 using current n; mismatch, unknown code, or MATRIX/VECTOR/START with n=0 -> frame_err, IDLE.
REQ-019 CMD -> PAYLOAD if L>1, else END; PAYLOAD -> END after L-1 payload bytes.
REQ-020 END: 0xEF -> EXEC; any other byte -> frame_err, IDLE.
REQ-021 MATRIX payload byte k (row-major, k=0..N*N-1) drives row_wr bit floor(k/N) and wr_data=byte, exactly one cycle after its rx_valid; row/column counters, no divider.
REQ-022 VECTOR payload byte drives vec_wr and wr_data one cycle after its rx_valid.
REQ-023 SIZE: payload N outside 1..8 -> frame_err at END byte, n unchanged; valid N applied in EXEC, with clear pulse and loaded flags cleared.
REQ-024 Internal flags m_loaded/v_loaded set in EXEC of a valid MATRIX/VECTOR frame; cleared on CLEAN, SIZE, error on a MATRIX/VECTOR frame, or reset.
REQ-025 START in EXEC: both flags set -> start pulse, busy=1, WAIT_DONE; otherwise frame_err, IDLE.
REQ-026 CLEAN in EXEC: clear pulse, flags cleared, IDLE.
REQ-027 Any frame_err during or after a MATRIX/VECTOR payload also pulses clear in the same cycle.
REQ-028 WAIT_DONE: rx bytes dropped silently; compute_done -> busy=0, IDLE next cycle.
REQ-029 compute_done outside WAIT_DONE ignored.
REQ-030 row_wr, vec_wr, start, clear, frame_err never high two consecutive cycles from a single event.

Reset
REQ-031 rst_n low: state IDLE, n=0, row_wr=0, vec_wr=0, wr_data=0, clear=0, start=0, frame_err=0, busy=0, flags and counters 0, effective immediately.
REQ-032 Reset mid-frame or mid-computation discards the frame; no pulse is emitted on reset release.

Structure
REQ-033 mxv_pkg holds the controller state enum, command codes, HDR=0xFE, EOF=0xEF, N_MAX=8, and the n_t width typedef.
REQ-034 One sub-module, mxv_rowcol_cnt: row/column counters with wrap at n, generating the one-hot row select and last-byte flag.

Verification
REQ-035 Reset, SIZE frame FE 02 01 03 EF -> n=3, one clear pulse, no frame_err.
REQ-036 With n=3, MATRIX FE 0A 03 01..09 EF -> row_wr 001,001,001,010,010,010,100,100,100 with wr_data 01..09, each one cycle after byte.
REQ-037 Load matrix and VECTOR FE 04 04 0A 0B 0C EF, then START FE 01 02 EF -> start pulse, busy=1 until compute_done; bytes during busy produce no outputs.
REQ-038 START with vector not loaded -> frame_err, no start; MATRIX with wrong L (FE 05 03 ...) -> frame_err at CMD byte.
REQ-039 Bad end byte (FE 01 05 AA) -> frame_err, no clear from CLEAN; SIZE N=9 -> frame_err, n unchanged.
REQ-040 rst_n asserted mid-MATRIX payload -> outputs 0 immediately; after release, next valid frame parsed normally.

Source files
------------

// File: rtl/mxv_pkg.sv
// Shared definitions for the MxV frame controller: state encoding,
// command codes, framing bytes and the dimension type.
package mxv_pkg;

    localparam int unsigned N_MAX = 8;
    localparam logic [7:0]  HDR   = 8'hFE;
    localparam logic [7:0]  EOF   = 8'hEF;

    // Dimension register: 0 = unconfigured, 1..N_MAX = configured size
    typedef logic [3:0] n_t;

    typedef enum logic [7:0] {
        CMD_SIZE   = 8'h01,
        CMD_START  = 8'h02,
        CMD_MATRIX = 8'h03,
        CMD_VECTOR = 8'h04,
        CMD_CLEAN  = 8'h05
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_CMD,
        S_PAYLOAD,
        S_END,
        S_EXEC,
        S_WAIT_DONE
    } state_e;

    // One-hot select for a matrix row index
    function automatic logic [N_MAX-1:0] row_onehot(input logic [2:0] r);
        row_onehot    = '0;
        row_onehot[r] = 1'b1;
    endfunction

endpackage

// File: rtl/mxv_rowcol_cnt.sv
// Row/column position tracker for matrix and vector payloads. Columns wrap
// at n and carry into the row, so no divide is needed to find the row of a
// row-major byte index.
module mxv_rowcol_cnt
    import mxv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic             vec_mode,
    input  n_t               n,
    output logic [N_MAX-1:0] row_sel,
    output logic             last
);

    logic [2:0] row;
    logic [2:0] col;
    logic       col_end;
    logic       row_end;

    assign col_end = ({1'b0, col} == (n - 4'd1));
    assign row_end = ({1'b0, row} == (n - 4'd1));

    assign row_sel = row_onehot(row);
    // A vector is a single row of n bytes; a matrix ends on the last column of the last row
    assign last    = col_end && (vec_mode || row_end);

    // Advance column per payload byte, carrying into the row at column n-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? 3'd0 : row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mxv_frame_ctrl.sv
// UART frame parser and sequencer for the MxV accelerator. Decodes
// FE/L/CMD/payload/EF frames, steers matrix and vector bytes into the
// FIFOs, and launches/tracks a computation.
module mxv_frame_ctrl
    import mxv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       compute_done,
    output logic [3:0] n,
    output logic [7:0] row_wr,
    output logic       vec_wr,
    output logic [7:0] wr_data,
    output logic       clear,
    output logic       start,
    output logic       frame_err,
    output logic       busy
);

    state_e     state;
    cmd_e       cmd_q;
    logic [7:0] len_q;
    logic [7:0] size_q;
    logic       m_loaded;
    logic       v_loaded;

    logic [7:0] n_sq;
    logic       n_zero;
    logic       cmd_ok;
    logic       size_ok;
    logic       is_mv;

    logic [N_MAX-1:0] row_sel;
    logic             cnt_last;
    logic             cnt_clr;
    logic             cnt_adv;

    assign n_sq    = {4'b0, n} * {4'b0, n};
    assign n_zero  = (n == '0);
    assign size_ok = (size_q != 8'd0) && (size_q <= 8'(N_MAX));
    assign is_mv   = (cmd_q == CMD_MATRIX) || (cmd_q == CMD_VECTOR);

    assign cnt_clr = (state == S_CMD) && rx_valid;
    assign cnt_adv = (state == S_PAYLOAD) && rx_valid && is_mv;

    mxv_rowcol_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .adv      (cnt_adv),
        .vec_mode (cmd_q == CMD_VECTOR),
        .n        (n),
        .row_sel  (row_sel),
        .last     (cnt_last)
    );

    // Validate the command byte and declared length against the current dimension
    always_comb begin
        cmd_ok = 1'b0;
        case (rx_data)
            CMD_SIZE:   cmd_ok = (len_q == 8'd2);
            CMD_START:  cmd_ok = !n_zero && (len_q == 8'd1);
            CMD_MATRIX: cmd_ok = !n_zero && (len_q == 8'd1 + n_sq);
            CMD_VECTOR: cmd_ok = !n_zero && (len_q == 8'd1 + {4'b0, n});
            CMD_CLEAN:  cmd_ok = (len_q == 8'd1);
            default:    cmd_ok = 1'b0;
        endcase
    end

    // Frame FSM with registered single-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_q     <= CMD_SIZE;
            len_q     <= '0;
            size_q    <= '0;
            m_loaded  <= 1'b0;
            v_loaded  <= 1'b0;
            n         <= '0;
            row_wr    <= '0;
            vec_wr    <= 1'b0;
            wr_data   <= '0;
            clear     <= 1'b0;
            start     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            row_wr    <= '0;
            vec_wr    <= 1'b0;
            clear     <= 1'b0;
            start     <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == HDR))
                        state <= S_LEN;
                end

                S_LEN: begin
                    if (rx_valid) begin
                        len_q <= rx_data;
                        state <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (rx_valid) begin
                        if (cmd_ok) begin
                            cmd_q <= cmd_e'(rx_data);
                            state <= (len_q > 8'd1) ? S_PAYLOAD : S_END;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (rx_valid) begin
                        case (cmd_q)
                            CMD_MATRIX: begin
                                row_wr  <= row_sel;
                                wr_data <= rx_data;
                                if (cnt_last)
                                    state <= S_END;
                            end
                            CMD_VECTOR: begin
                                vec_wr  <= 1'b1;
                                wr_data <= rx_data;
                                if (cnt_last)
                                    state <= S_END;
                            end
                            default: begin
                                // SIZE carries exactly one payload byte
                                size_q <= rx_data;
                                state  <= S_END;
                            end
                        endcase
                    end
                end

                S_END: begin
                    if (rx_valid) begin
                        if (rx_data != EOF) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                            // FIFOs may hold a partial matrix/vector: flush and forget it
                            if (is_mv) begin
                                clear    <= 1'b1;
                                m_loaded <= 1'b0;
                                v_loaded <= 1'b0;
                            end
                        end else if ((cmd_q == CMD_SIZE) && !size_ok) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    state <= S_IDLE;
                    case (cmd_q)
                        CMD_SIZE: begin
                            n        <= size_q[3:0];
                            clear    <= 1'b1;
                            m_loaded <= 1'b0;
                            v_loaded <= 1'b0;
                        end
                        CMD_MATRIX: m_loaded <= 1'b1;
                        CMD_VECTOR: v_loaded <= 1'b1;
                        CMD_START: begin
                            if (m_loaded && v_loaded) begin
                                start <= 1'b1;
                                busy  <= 1'b1;
                                state <= S_WAIT_DONE;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                        default: begin
                            clear    <= 1'b1;
                            m_loaded <= 1'b0;
                            v_loaded <= 1'b0;
                        end
                    endcase
                end

                S_WAIT_DONE: begin
                    if (compute_done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
